// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_universal
//  Description : Parametrised universal shift register. One FSM (IDLE/RX/TX)
//                owns a serial-to-parallel receive path and a
//                parallel-to-serial transmit path. Bit order is selectable
//                per frame, and the block reports a frame bit counter and
//                valid/busy handshakes. It also supports stall (en) and
//                abort (clr).
//  Ports       : clk, reset_n (async, active-low)
//                en            - clock enable, 0 holds all state
//                clr           - synchronous abort to IDLE, ignores en
//                dir           - 0 LSB-first, 1 MSB-first (latched at frame start)
//                ser_in/ser_in_valid - serial receive bit and its qualifier
//                load/par_in   - start a transmit frame with par_in
//                ser_out/ser_out_valid - serial transmit bit and its qualifier
//                par_out/par_out_valid - last received word, one-cycle pulse
//                busy          - frame in progress (RX or TX)
//                bit_cnt       - bits moved in the current frame
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_universal #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             dir,
    input  logic             ser_in,
    input  logic             ser_in_valid,
    input  logic             load,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             par_out_valid,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt
);

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RX   = 2'd1;
    localparam logic [1:0]    c_TX   = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_dir_q;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_par_out;
    logic             r_par_out_valid;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic             w_dir_nxt;
    logic [CW-1:0]    w_bit_cnt_nxt;
    logic [WIDTH-1:0] w_par_out_nxt;
    logic             w_par_out_valid_nxt;
    logic             w_rx_dir;
    logic [WIDTH-1:0] w_rx_shift;
    logic [WIDTH-1:0] w_tx_shift;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_IDLE;
            r_shreg         <= '0;
            r_dir_q         <= 1'b0;
            r_bit_cnt       <= '0;
            r_par_out       <= '0;
            r_par_out_valid <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_shreg         <= w_shreg_nxt;
            r_dir_q         <= w_dir_nxt;
            r_bit_cnt       <= w_bit_cnt_nxt;
            r_par_out       <= w_par_out_nxt;
            r_par_out_valid <= w_par_out_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt         = r_state;
        w_shreg_nxt         = r_shreg;
        w_dir_nxt           = r_dir_q;
        w_bit_cnt_nxt       = r_bit_cnt;
        w_par_out_nxt       = r_par_out;
        // The completion pulse lasts exactly one cycle, even under stall.
        w_par_out_valid_nxt = 1'b0;

        // The first received bit is shifted with the live dir because
        // dir_q is only being captured on that same edge.
        w_rx_dir   = (r_state == c_IDLE) ? dir : r_dir_q;
        w_rx_shift = w_rx_dir ? {r_shreg[WIDTH-2:0], ser_in}
                              : {ser_in, r_shreg[WIDTH-1:1]};
        w_tx_shift = r_dir_q  ? {r_shreg[WIDTH-2:0], 1'b0}
                              : {1'b0, r_shreg[WIDTH-1:1]};

        if (clr) begin
            w_state_nxt   = c_IDLE;
            w_bit_cnt_nxt = '0;
            w_shreg_nxt   = '0;
        end else if (en) begin
            case (r_state)
                c_IDLE: begin
                    // load has priority; a simultaneous serial bit is dropped
                    if (load) begin
                        w_shreg_nxt   = par_in;
                        w_dir_nxt     = dir;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = c_TX;
                    end else if (ser_in_valid) begin
                        w_shreg_nxt   = w_rx_shift;
                        w_dir_nxt     = dir;
                        w_bit_cnt_nxt = CW'(1);
                        w_state_nxt   = c_RX;
                    end
                end
                c_RX: begin
                    if (ser_in_valid) begin
                        w_shreg_nxt = w_rx_shift;
                        if (r_bit_cnt == c_LAST) begin
                            w_par_out_nxt       = w_rx_shift;
                            w_par_out_valid_nxt = 1'b1;
                            w_bit_cnt_nxt       = '0;
                            w_state_nxt         = c_IDLE;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                        end
                    end
                end
                c_TX: begin
                    w_shreg_nxt = w_tx_shift;
                    if (r_bit_cnt == c_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = c_IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt   = c_IDLE;
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy          = (r_state != c_IDLE);
    assign ser_out       = (r_state == c_TX) ? (r_dir_q ? r_shreg[WIDTH-1] : r_shreg[0]) : 1'b0;
    assign ser_out_valid = (r_state == c_TX) & en;
    assign par_out       = r_par_out;
    assign par_out_valid = r_par_out_valid;
    assign bit_cnt       = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_reg_universal
//  Description : Self-checking bench for shift_reg_universal. An 8-bit
//                instance is compared every cycle against a frame-level
//                model; directed frames add literal expectations. A 16-bit
//                instance runs an RX/TX round trip.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_universal;

    logic clk;
    logic reset_n;
    logic en, clr;

    // 8-bit instance
    logic       dir, ser_in, ser_in_valid, load;
    logic [7:0] par_in;
    logic       ser_out8, sov8, pov8, busy8;
    logic [7:0] par_out8;
    logic [3:0] bit_cnt8;

    // 16-bit instance
    logic        dir16, ser_in16, siv16, load16;
    logic [15:0] par_in16;
    logic        ser_out16, sov16, pov16, busy16;
    logic [15:0] par_out16;
    logic [4:0]  bit_cnt16;

    shift_reg_universal #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .dir(dir),
        .ser_in(ser_in), .ser_in_valid(ser_in_valid), .load(load), .par_in(par_in),
        .ser_out(ser_out8), .ser_out_valid(sov8), .par_out(par_out8),
        .par_out_valid(pov8), .busy(busy8), .bit_cnt(bit_cnt8)
    );

    shift_reg_universal #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .dir(dir16),
        .ser_in(ser_in16), .ser_in_valid(siv16), .load(load16), .par_in(par_in16),
        .ser_out(ser_out16), .ser_out_valid(sov16), .par_out(par_out16),
        .par_out_valid(pov16), .busy(busy16), .bit_cnt(bit_cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Frame-level model of the 8-bit instance: mode, bit index within the
    // frame, the word being sent and the word being assembled bit by bit.
    // ------------------------------------------------------------------
    int         m_mode;   // 0 idle, 1 receiving, 2 transmitting
    int         m_cnt;
    logic       m_dir;
    logic [7:0] m_tx, m_rx, m_par;
    logic       m_pov;

    function automatic logic [7:0] put_bit(input logic [7:0] w, input int pos, input logic b);
        logic [7:0] r;
        r = w;
        r[pos] = b;
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0; m_cnt <= 0; m_dir <= 1'b0;
            m_tx <= '0; m_rx <= '0; m_par <= '0; m_pov <= 1'b0;
        end else begin
            m_pov <= 1'b0;
            if (clr) begin
                m_mode <= 0;
                m_cnt  <= 0;
            end else if (en) begin
                if (m_mode == 0) begin
                    if (load) begin
                        m_tx <= par_in; m_dir <= dir; m_cnt <= 0; m_mode <= 2;
                    end else if (ser_in_valid) begin
                        m_rx <= put_bit(8'h00, dir ? 7 : 0, ser_in);
                        m_dir <= dir; m_cnt <= 1; m_mode <= 1;
                    end
                end else if (m_mode == 1) begin
                    if (ser_in_valid) begin
                        if (m_cnt == 7) begin
                            m_par  <= put_bit(m_rx, m_dir ? 0 : 7, ser_in);
                            m_pov  <= 1'b1;
                            m_mode <= 0;
                            m_cnt  <= 0;
                        end else begin
                            m_rx  <= put_bit(m_rx, m_dir ? 7 - m_cnt : m_cnt, ser_in);
                            m_cnt <= m_cnt + 1;
                        end
                    end
                end else begin
                    if (m_cnt == 7) begin
                        m_mode <= 0; m_cnt <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            end
        end
    end

    function automatic logic exp_ser_out();
        if (m_mode != 2) return 1'b0;
        return m_tx[m_dir ? 7 - m_cnt : m_cnt];
    endfunction

    // Single per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",          32'(busy8),    32'(m_mode != 0));
            check("bit_cnt",       32'(bit_cnt8), 32'(m_cnt));
            check("ser_out",       32'(ser_out8), 32'(exp_ser_out()));
            check("ser_out_valid", 32'(sov8),     32'((m_mode == 2) && en));
            check("par_out",       32'(par_out8), 32'(m_par));
            check("par_out_valid", 32'(pov8),     32'(m_pov));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic [7:0]  tx_seq;     // first transmitted bit ends up in the MSB
    int          tx_n;
    int          pov_n;
    int          pov_cyc;
    logic        so_last, sov_last;
    logic [15:0] rec16;
    int          n16;
    bit          rec16_msb;

    task automatic cycle();
        @(negedge clk);
        so_last  = ser_out8;
        sov_last = sov8;
        if (sov8) begin tx_seq = {tx_seq[6:0], ser_out8}; tx_n++; end
        if (pov8) begin pov_n++; pov_cyc = cyc; end
        if (sov16 && n16 < 16) begin
            rec16[rec16_msb ? 15 - n16 : n16] = ser_out16;
            n16++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rx_word8(input logic [7:0] w, input logic d, input int gap_at, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                ser_in_valid = 1'b0;
                repeat (gap_len) cycle();
            end
            dir = d; ser_in = d ? w[7-i] : w[i]; ser_in_valid = 1'b1;
            cycle();
        end
        ser_in_valid = 1'b0; ser_in = 1'b0;
    endtask

    task automatic tx_word8(input logic [7:0] w, input logic d);
        tx_seq = '0; tx_n = 0;
        load = 1'b1; par_in = w; dir = d;
        cycle();
        load = 1'b0;
        repeat (10) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int c0;

    initial begin
        reset_n = 1'b0; en = 1'b1; clr = 1'b0;
        dir = 1'b0; ser_in = 1'b0; ser_in_valid = 1'b0; load = 1'b0; par_in = '0;
        dir16 = 1'b0; ser_in16 = 1'b0; siv16 = 1'b0; load16 = 1'b0; par_in16 = '0;
        tx_seq = '0; tx_n = 0; pov_n = 0; pov_cyc = -1; rec16 = '0; n16 = 0; rec16_msb = 1'b0;
        so_last = 1'b0; sov_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",    32'(busy8),    32'd0);
        check("reset par_out", 32'(par_out8), 32'd0);
        check("reset bit_cnt", 32'(bit_cnt8), 32'd0);
        check("reset ser_out", 32'(ser_out8), 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        cycle();

        // 1: RX 0xBC LSB-first, back to back
        pov_n = 0; c0 = cyc;
        rx_word8(8'hBC, 1'b0, -1, 0);
        repeat (2) cycle();
        check("t1 par_out",   32'(par_out8), 32'hBC);
        check("t1 pulses",    32'(pov_n),    32'd1);
        check("t1 pulse cyc", 32'(pov_cyc),  32'(c0 + 8));
        check("t1 busy",      32'(busy8),    32'd0);
        check("t1 bit_cnt",   32'(bit_cnt8), 32'd0);

        // 2: same frame with a 3-cycle gap after bit 4
        pov_n = 0; c0 = cyc;
        rx_word8(8'hBC, 1'b0, 4, 3);
        repeat (2) cycle();
        check("t2 par_out",   32'(par_out8), 32'hBC);
        check("t2 pulses",    32'(pov_n),    32'd1);
        check("t2 pulse cyc", 32'(pov_cyc),  32'(c0 + 11));

        // 3: TX 0xBC both bit orders
        tx_word8(8'hBC, 1'b0);
        check("t3 lsb count", 32'(tx_n),   32'd8);
        check("t3 lsb bits",  32'(tx_seq), 32'h3D);
        check("t3 busy",      32'(busy8),  32'd0);
        tx_word8(8'hBC, 1'b1);
        check("t3 msb count", 32'(tx_n),   32'd8);
        check("t3 msb bits",  32'(tx_seq), 32'hBC);

        // 4: TX with a 5-cycle stall while bit 3 is on the line
        tx_seq = '0; tx_n = 0;
        load = 1'b1; par_in = 8'hBC; dir = 1'b0;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t4 hold bit",   32'(so_last),  32'd1);
            check("t4 hold valid", 32'(sov_last), 32'd0);
        end
        en = 1'b1;
        repeat (10) cycle();
        check("t4 count", 32'(tx_n),   32'd8);
        check("t4 bits",  32'(tx_seq), 32'h3D);

        // 5a: load and serial bit together in IDLE -> transmit only
        pov_n = 0; tx_seq = '0; tx_n = 0;
        load = 1'b1; ser_in_valid = 1'b1; ser_in = 1'b1; par_in = 8'h35; dir = 1'b0;
        cycle();
        load = 1'b0; ser_in_valid = 1'b0; ser_in = 1'b0;
        repeat (10) cycle();
        check("t5 tx count",  32'(tx_n),     32'd8);
        check("t5 tx bits",   32'(tx_seq),   32'hAC);
        check("t5 no rx",     32'(pov_n),    32'd0);
        check("t5 par kept",  32'(par_out8), 32'hBC);

        // 5b: load requests during RX are ignored
        tx_n = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h3C;
            dir = 1'b0; ser_in = w[i]; ser_in_valid = 1'b1;
            load = (i >= 2 && i <= 4); par_in = 8'hFF;
            cycle();
        end
        load = 1'b0; ser_in_valid = 1'b0;
        repeat (2) cycle();
        check("t5 rx ignore load", 32'(par_out8), 32'h3C);
        check("t5 no tx",          32'(tx_n),     32'd0);

        // 5c: abort an RX frame after 5 bits
        rx_word8(8'hBC, 1'b0, -1, 0);
        repeat (2) cycle();
        pov_n = 0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] w;
            w = 8'h0F;
            ser_in = w[i]; ser_in_valid = 1'b1;
            cycle();
        end
        check("t5 mid-frame cnt", 32'(bit_cnt8), 32'd5);
        clr = 1'b1;
        cycle();
        clr = 1'b0; ser_in_valid = 1'b0;
        repeat (3) cycle();
        check("t5 clr busy",    32'(busy8),    32'd0);
        check("t5 clr bit_cnt", 32'(bit_cnt8), 32'd0);
        check("t5 clr par_out", 32'(par_out8), 32'hBC);
        check("t5 clr pulses",  32'(pov_n),    32'd0);

        // 6: asynchronous reset in the middle of a TX frame
        load = 1'b1; par_in = 8'hFF; dir = 1'b1;
        cycle();
        load = 1'b0;
        repeat (2) cycle();
        check("t6 pre ser_out", 32'(ser_out8), 32'd1);
        check("t6 pre busy",    32'(busy8),    32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6 ser_out",       32'(ser_out8), 32'd0);
        check("t6 ser_out_valid", 32'(sov8),     32'd0);
        check("t6 busy",          32'(busy8),    32'd0);
        check("t6 bit_cnt",       32'(bit_cnt8), 32'd0);
        check("t6 par_out",       32'(par_out8), 32'd0);
        check("t6 par_out_valid", 32'(pov8),     32'd0);
        cycle();
        reset_n = 1'b1;
        cycle();

        // WIDTH=16: receive 0xA5C3 MSB-first, then transmit it both ways
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'hA5C3;
            dir16 = 1'b1; ser_in16 = w[15-i]; siv16 = 1'b1;
            cycle();
        end
        siv16 = 1'b0; ser_in16 = 1'b0;
        repeat (2) cycle();
        check("w16 rx par_out", 32'(par_out16), 32'hA5C3);
        check("w16 rx busy",    32'(busy16),    32'd0);

        n16 = 0; rec16 = '0; rec16_msb = 1'b0;
        load16 = 1'b1; par_in16 = 16'hA5C3; dir16 = 1'b0;
        cycle();
        load16 = 1'b0;
        repeat (18) cycle();
        check("w16 tx lsb count", 32'(n16),   32'd16);
        check("w16 tx lsb word",  32'(rec16), 32'hA5C3);

        n16 = 0; rec16 = '0; rec16_msb = 1'b1;
        load16 = 1'b1; par_in16 = 16'hA5C3; dir16 = 1'b1;
        cycle();
        load16 = 1'b0;
        repeat (18) cycle();
        check("w16 tx msb count", 32'(n16),   32'd16);
        check("w16 tx msb word",  32'(rec16), 32'hA5C3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
